instr_fetch: RTL and testbench

- Fetch stage directly downstream of the PC register. Takes the current `pc`, issues one word read to instruction memory over a req/gnt/rvalid handshake, and holds the returned instruction for decode until it is consumed.
- Returns `enpc` to the PC stage, so the PC advances only when an instruction is consumed.
- One outstanding request at a time. Supports flush, misaligned-PC detection and a memory timeout.

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word read per instruction over a
// req/gnt/rvalid handshake and holds the result for decode until consumed.
module instr_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err,
    output logic        enpc
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrop} state_e;

    // Last counter value before a wait is declared timed out.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic               fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    // Next-state logic for the fetch FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Latch pc so an in-flight request is immune to pc changes.
                addr_d     = pc;
                instr_pc_d = pc;
                if (pc[1:0] != 2'b00) begin
                    state_d     = StHold;
                    fetch_err_d = 1'b1;
                    instr_d     = NOP_INSTR;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (imem_gnt) begin
                    cnt_d   = '0;
                    state_d = flush ? StDrop : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        instr_d     = imem_rdata;
                        fetch_err_d = 1'b0;
                        state_d     = StHold;
                    end
                end else if (flush) begin
                    // Response still owed by memory; it must be swallowed.
                    cnt_d   = '0;
                    state_d = StDrop;
                end else if (timeout_hit) begin
                    fetch_err_d = 1'b1;
                    instr_d     = NOP_INSTR;
                    state_d     = StHold;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (flush || id_ready) begin
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (imem_rvalid || timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= '0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == StHold);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;
    assign enpc        = instr_valid & id_ready & ~flush;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch; a second instance with a short timeout
// covers the memory-timeout path.
module tb_instr_fetch;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, flush, imem_gnt, imem_rvalid, id_ready;
    logic [31:0] pc, imem_rdata;

    logic        imem_req, instr_valid, fetch_err, enpc;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        t_imem_req, t_instr_valid, t_fetch_err, t_enpc;
    logic [31:0] t_imem_addr, t_instr, t_instr_pc;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .fetch_err(fetch_err), .enpc(enpc)
    );

    instr_fetch #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .imem_req(t_imem_req), .imem_addr(t_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
        .instr_valid(t_instr_valid), .instr(t_instr), .instr_pc(t_instr_pc),
        .fetch_err(t_fetch_err), .enpc(t_enpc)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        id_ready = 1'b0; imem_rdata = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pc = 32'h0000_0000;
        do_reset();
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL rst_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        n_checks++; if (instr !== Nop) begin n_fails++; $display("FAIL rst_instr got %h exp %h", instr, Nop); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fails++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("FAIL rst_err got %b exp 0", fetch_err); end
        n_checks++; if (enpc !== 1'b0) begin n_fails++; $display("FAIL rst_enpc got %b exp 0", enpc); end
    endtask

    task automatic test_basic_fetch();
        pc = 32'h0000_0000;
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b1;
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL basic_idle_req got %b exp 0", imem_req); end
        tick();  // REQ
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fails++; $display("FAIL basic_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        tick();  // WAIT
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        settle();
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fails++; $display("FAIL basic_wait got req=%b valid=%b exp 0/0", imem_req, instr_valid); end
        tick();  // HOLD
        imem_rvalid = 1'b0;
        settle();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin n_fails++; $display("FAIL basic_hold got valid=%b instr=%h pc=%h exp 1/00500093/0", instr_valid, instr, instr_pc); end
        n_checks++; if (enpc !== 1'b1) begin n_fails++; $display("FAIL basic_enpc got %b exp 1", enpc); end
        tick();  // IDLE
        n_checks++; if (instr_valid !== 1'b0 || enpc !== 1'b0 || imem_req !== 1'b0) begin n_fails++; $display("FAIL basic_idle_again got valid=%b enpc=%b req=%b exp 0/0/0", instr_valid, enpc, imem_req); end
        id_ready = 1'b0;
    endtask

    task automatic test_slow_handshake();
        int req_cycles = 0;
        pc = 32'h0000_0010;
        do_reset();
        tick();  // REQ
        for (int i = 0; i < 4; i++) begin
            if (imem_req === 1'b1) req_cycles++;
            n_checks++; if (imem_addr !== 32'h10) begin n_fails++; $display("FAIL slow_addr cyc %0d got %h exp 10", i, imem_addr); end
            imem_gnt = (i == 3);
            tick();
        end
        imem_gnt = 1'b0;
        if (imem_req === 1'b1) req_cycles++;
        n_checks++; if (req_cycles != 4) begin n_fails++; $display("FAIL slow_req_cycles got %0d exp 4", req_cycles); end
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 4); imem_rdata = 32'h1234_5678;
            tick();
        end
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h10 || enpc !== 1'b0) begin n_fails++; $display("FAIL slow_hold cyc %0d got valid=%b instr=%h pc=%h enpc=%b exp 1/12345678/10/0", i, instr_valid, instr, instr_pc, enpc); end
            tick();
        end
        id_ready = 1'b1;
        settle();
        n_checks++; if (enpc !== 1'b1) begin n_fails++; $display("FAIL slow_enpc got %b exp 1", enpc); end
        tick();
        id_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL slow_consumed got %b exp 0", instr_valid); end
    endtask

    task automatic test_misaligned();
        pc = 32'h0000_0006;
        do_reset();
        imem_gnt = 1'b1;
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL mis_idle_req got %b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL mis_req got %b exp 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b1 || instr !== Nop || instr_pc !== 32'h6) begin n_fails++; $display("FAIL mis_hold got valid=%b err=%b instr=%h pc=%h exp 1/1/13/6", instr_valid, fetch_err, instr, instr_pc); end
        imem_gnt = 1'b0;
    endtask

    task automatic test_timeout();
        pc = 32'h0000_0020;
        do_reset();
        imem_gnt = 1'b1;
        tick();  // REQ
        tick();  // WAIT, counter 0
        imem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (t_instr_valid !== 1'b0) begin n_fails++; $display("FAIL to_wait cyc %0d got valid=%b exp 0", i, t_instr_valid); end
            tick();
        end
        n_checks++; if (t_instr_valid !== 1'b1 || t_fetch_err !== 1'b1 || t_instr !== Nop || t_instr_pc !== 32'h20) begin n_fails++; $display("FAIL to_hold got valid=%b err=%b instr=%h pc=%h exp 1/1/13/20", t_instr_valid, t_fetch_err, t_instr, t_instr_pc); end
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (t_instr_valid !== 1'b1 || t_fetch_err !== 1'b1 || t_instr !== Nop) begin n_fails++; $display("FAIL to_late_rvalid got valid=%b err=%b instr=%h exp 1/1/13", t_instr_valid, t_fetch_err, t_instr); end
    endtask

    task automatic test_flush_wait();
        pc = 32'h0000_0040;
        do_reset();
        imem_gnt = 1'b1;
        tick();  // REQ
        tick();  // WAIT
        imem_gnt = 1'b0; flush = 1'b1;
        tick();  // DROP
        flush = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fails++; $display("FAIL flush_drop got valid=%b req=%b exp 0/0", instr_valid, imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc = 32'h0000_0100;
        tick();  // IDLE
        imem_rvalid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) begin n_fails++; $display("FAIL flush_discard got valid=%b instr=%h exp 0/not deadbeef", instr_valid, instr); end
        imem_gnt = 1'b1;
        tick();  // REQ
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fails++; $display("FAIL flush_newreq got req=%b addr=%h exp 1/100", imem_req, imem_addr); end
        tick();  // WAIT
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();  // HOLD
        imem_rvalid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h100) begin n_fails++; $display("FAIL flush_refetch got valid=%b instr=%h pc=%h exp 1/00a00113/100", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_flush_hold_and_reset_wait();
        pc = 32'h0000_0000;
        do_reset();
        imem_gnt = 1'b1;
        tick(); tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        tick();  // HOLD
        imem_rvalid = 1'b0; flush = 1'b1; id_ready = 1'b1;
        settle();
        n_checks++; if (instr_valid !== 1'b1 || enpc !== 1'b0) begin n_fails++; $display("FAIL hold_flush_enpc got valid=%b enpc=%b exp 1/0", instr_valid, enpc); end
        tick();
        flush = 1'b0; id_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL hold_flush_drop got %b exp 0", instr_valid); end
        // Reset while waiting for read data.
        pc = 32'h0000_0080;
        do_reset();
        imem_gnt = 1'b1;
        tick(); tick();  // WAIT
        imem_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== Nop || instr_pc !== 32'h0 || fetch_err !== 1'b0 || enpc !== 1'b0) begin n_fails++; $display("FAIL wait_rst got req=%b addr=%h valid=%b instr=%h pc=%h err=%b enpc=%b exp all reset", imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err, enpc); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
        tick();  // REQ
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin n_fails++; $display("FAIL wait_rst_rvalid1 got valid=%b req=%b exp 0/1", instr_valid, imem_req); end
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || instr === 32'hBADB_AD00) begin n_fails++; $display("FAIL wait_rst_rvalid2 got valid=%b instr=%h exp 0/not badbad00", instr_valid, instr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc = '0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_slow_handshake();
        test_misaligned();
        test_timeout();
        test_flush_wait();
        test_flush_hold_and_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
